// File: rtl/spypath_capture.sv
// spypath_capture: measures delay-path latency by averaging 2^TRIALS_LOG2 launch/capture trials
module spypath_capture #(
  parameter int CNT_W       = 16,
  parameter int TRIALS_LOG2 = 3,
  parameter int TIMEOUT     = 1023,
  parameter int SETTLE_CYC  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         path_result,
  output logic                         path_input,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout_err,
  output logic [CNT_W+TRIALS_LOG2-1:0] delay_sum,
  output logic [CNT_W-1:0]             delay_mean
);
  localparam int SW = CNT_W + TRIALS_LOG2;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, DONE} state_t;
  state_t state;
  logic sync_d, sync_q;
  logic [CNT_W-1:0] cnt;
  logic [TRIALS_LOG2-1:0] idx;
  assign delay_mean = delay_sum[SW-1:TRIALS_LOG2];
  // cnt doubles as the settle timer, since WAIT and SETTLE never overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sync_d      <= 1'b0;
      sync_q      <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      path_input  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      delay_sum   <= '0;
    end else begin
      sync_d <= path_result;
      sync_q <= sync_d;
      done   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= LAUNCH;
          busy        <= 1'b1;
          delay_sum   <= '0;
          idx         <= '0;
          timeout_err <= 1'b0;
        end
        LAUNCH: begin
          path_input <= ~path_input;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: if (sync_q == path_input) begin
          delay_sum <= delay_sum + SW'(cnt);
          if (&idx) begin
            state      <= DONE;
            done       <= 1'b1;
            path_input <= 1'b0;
          end else begin
            idx   <= idx + 1'b1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          timeout_err <= 1'b1;
          state       <= DONE;
          done        <= 1'b1;
          path_input  <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state <= LAUNCH;
                else cnt <= cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spypath_capture.sv
// tb_spypath_capture: random delay paths checked against an arithmetic trial model
module tb_spypath_capture;
  localparam int CW = 16, TL = 3, TO = 1023, SC = 16, NT = 1 << TL;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic path_result, path_input, busy, done, timeout_err;
  logic [CW+TL-1:0] delay_sum;
  logic [CW-1:0] delay_mean;
  int total = 0, bad = 0;
  int rise_d = 0, fall_d = 0;
  bit stuck = 1'b0;
  logic [15:0] hist = '0;
  logic rv, fv;
  always #5 clk = ~clk;
  spypath_capture #(.CNT_W(CW), .TRIALS_LOG2(TL), .TIMEOUT(TO), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .path_result(path_result), .path_input(path_input),
    .busy(busy), .done(done), .timeout_err(timeout_err), .delay_sum(delay_sum), .delay_mean(delay_mean)
  );
  // path under test: output follows input after rise_d / fall_d clock edges
  always @(posedge clk) hist <= {hist[14:0], path_input};
  always_comb begin
    rv = (rise_d == 0) ? path_input : hist[rise_d-1];
    fv = (fall_d == 0) ? path_input : hist[fall_d-1];
    path_result = stuck ? 1'b0 : (path_input ? rv : fv);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // trials alternate rising/falling; each counts path delay plus 2 sync cycles
  function automatic int ref_sum(input int r, input int f, input bit s, output bit to);
    int sum = 0;
    to = 1'b0;
    for (int i = 0; i < NT; i++) begin
      int c = s ? TO + 1 : ((i % 2 == 0) ? r + 2 : f + 2);
      if (c > TO) begin
        to = 1'b1;
        return sum;
      end
      sum += c;
    end
    return sum;
  endfunction
  task automatic measure(input int r, input int f, input bit s, input bit rp);
    int n = 0;
    int es;
    bit eto;
    rise_d = r;
    fall_d = f;
    stuck = s;
    es = ref_sum(r, f, s, eto);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    while (!done && n < 5000) begin
      start = rp && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("delay_sum", delay_sum, es);
    chk("delay_mean", delay_mean, es >> TL);
    chk("timeout_err", timeout_err, eto);
    @(negedge clk);
    chk("done_single", done, 0);
    chk("path_idle", path_input, 0);
    chk("busy_idle", busy, 0);
    repeat (5) @(negedge clk);
    chk("sum_hold", delay_sum, es);
    chk("to_hold", timeout_err, eto);
    chk("no_restart", busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {path_input, busy, done, timeout_err, delay_sum}, 0);
    rst = 1'b0;
    measure(0, 0, 0, 0);
    measure(5, 5, 0, 0);
    measure(0, 0, 1, 0);
    measure(3, 1, 0, 0);
    measure(0, 0, 0, 1);
    for (int k = 0; k < 6; k++)
      measure($urandom_range(0, 10), $urandom_range(0, 10), 0, $urandom_range(0, 1));
    begin
      int tog = 0, n = 0;
      logic prev;
      rise_d = 0;
      fall_d = 0;
      stuck = 0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      prev = path_input;
      while (tog < 5 && n < 2000) begin
        @(negedge clk);
        if (path_input != prev) tog++;
        prev = path_input;
        n++;
      end
      chk("reach_trial4", tog, 5);
      chk("sum_before_rst", delay_sum, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst", {path_input, busy, done, timeout_err, delay_sum, delay_mean}, 0);
    end
    measure(0, 0, 0, 0);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_a", busy, 0);
    @(negedge clk);
    chk("rst_start_b", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spypath_capture.md
SPYPATH_CAPTURE -- requirements
Module: spypath_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the per-trial delay counter.
REQ-002 Parameter TRIALS_LOG2, default 3: log2 of the number of launch/capture trials per measurement (8 trials at default).
REQ-003 Parameter TIMEOUT, default 1023: WAIT-cycle count at which a trial is abandoned.
REQ-004 Parameter SETTLE_CYC, default 16: idle cycles between consecutive trials.
REQ-005 clk  input  1  single clock for all state.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin a measurement.
REQ-008 path_result  input  1  asynchronous output of the delay path under test.
REQ-009 path_input  output  1  launch signal driven into the delay path under test.
REQ-010 busy  output  1  high while a measurement is in progress.
REQ-011 done  output  1  one-cycle pulse when a measurement completes.
REQ-012 timeout_err  output  1  set when the measurement aborted on timeout; valid with done.
REQ-013 delay_sum  output  CNT_W+TRIALS_LOG2  sum of per-trial counts.
REQ-014 delay_mean  output  CNT_W  delay_sum >> TRIALS_LOG2.

Function
REQ-015 path_result SHALL pass through a 2-flop synchronizer (sync_q) before any use.
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT, SETTLE, DONE.
REQ-017 IDLE: path_input=0 and busy=0; start=1 -> LAUNCH, clears delay_sum, trial index and timeout_err; start in any other state SHALL be ignored.
REQ-018 LAUNCH (one cycle): path_input toggles, cnt clears to 0 -> WAIT.
REQ-019 WAIT, sync_q == path_input: delay_sum += cnt; if trial index == 2^TRIALS_LOG2-1 -> DONE, else trial index +1 -> SETTLE.
REQ-020 WAIT, no match and cnt == TIMEOUT: timeout_err=1 -> DONE, with delay_sum holding only the completed trials.
REQ-021 WAIT, no match and cnt < TIMEOUT: cnt += 1.
REQ-022 Consecutive trials alternate rising and falling launches, because path_input only toggles.
REQ-023 SETTLE: counts SETTLE_CYC cycles with path_input held -> LAUNCH.
REQ-024 DONE (one cycle): done=1, path_input forced to 0 -> IDLE.
REQ-025 busy SHALL be 1 in LAUNCH, WAIT, SETTLE and DONE.
REQ-026 delay_sum, delay_mean and timeout_err SHALL hold their values from DONE until the next accepted start.
REQ-027 cnt SHALL saturate, not wrap, at TIMEOUT; TIMEOUT SHALL be < 2^CNT_W.
REQ-028 delay_sum SHALL NOT overflow: its width covers 2^TRIALS_LOG2 trials of max count TIMEOUT.
REQ-029 Measured count for a zero-delay path SHALL be exactly 2 (synchronizer latency).

Reset
REQ-030 rst=1 at a clock edge SHALL, from any state including mid-trial, force: state IDLE, path_input=0, busy=0, done=0, timeout_err=0, delay_sum=0, cnt=0, trial index=0, synchronizer flops=0.
REQ-031 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-032 path_result tied to path_input, start pulse -> done after 8 trials; delay_sum=16, delay_mean=2, timeout_err=0.
REQ-033 path_result = path_input delayed by 5 clk -> delay_sum=56, delay_mean=7.
REQ-034 path_result stuck 0 -> trial 0 rising-edge launch never matches; done at cnt=1023, timeout_err=1, delay_sum=0, path_input=0 after DONE.
REQ-035 Delay path with rising delay 3 clk and falling delay 1 clk -> delay_sum=4*5+4*3=32, delay_mean=4.
REQ-036 rst pulse during WAIT of trial 4 -> next cycle IDLE, all outputs 0; a fresh start then gives the REQ-032 result.
REQ-037 start re-pulsed during WAIT and during SETTLE -> ignored; single done; results identical to REQ-032.
